// File: rtl/reg_read_bypass_stage.sv
// Register-read stage: drives RF read addresses, resolves operands against the
// forwarding buses and registers them behind a valid/ready handshake.
module reg_read_bypass_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 3,
    parameter int NUM_BYPASS = 2,
    parameter int PAYLOAD_W  = 128,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [NUM_SRC*ADDR_W-1:0]    in_src_addr,
    input  logic [NUM_SRC-1:0]           in_src_en,
    output logic [NUM_SRC*ADDR_W-1:0]    rf_read_addr,
    input  logic [NUM_SRC*XLEN-1:0]      rf_read_value,
    input  logic [NUM_BYPASS-1:0]        byp_valid,
    input  logic [NUM_BYPASS*ADDR_W-1:0] byp_addr,
    input  logic [NUM_BYPASS*XLEN-1:0]   byp_value,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [NUM_SRC*XLEN-1:0]      out_src_value
);

    logic [NUM_SRC*ADDR_W-1:0] src_addr_q;
    logic [NUM_SRC-1:0]        src_en_q;
    logic [NUM_SRC*XLEN-1:0]   cap_value;
    logic [NUM_SRC*XLEN-1:0]   snoop_value;
    logic                      accept;

    // Bypass loop runs high-to-low so the lowest matching index is written last and wins.
    function automatic logic [XLEN-1:0] resolve(
        input logic                         en,
        input logic [ADDR_W-1:0]            a,
        input logic [XLEN-1:0]              v,
        input logic [NUM_BYPASS-1:0]        bv,
        input logic [NUM_BYPASS*ADDR_W-1:0] ba,
        input logic [NUM_BYPASS*XLEN-1:0]   bd
    );
        logic [XLEN-1:0] r;
        r = v;
        for (int j = NUM_BYPASS - 1; j >= 0; j--) begin
            if (bv[j] && (ba[j*ADDR_W +: ADDR_W] == a)) begin
                r = bd[j*XLEN +: XLEN];
            end
        end
        if (ZERO_REG && (a == '0)) begin
            r = '0;
        end
        if (!en) begin
            r = '0;
        end
        return r;
    endfunction

    assign rf_read_addr = in_src_addr;
    assign in_ready     = !flush && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;

    always_comb begin
        cap_value   = '0;
        snoop_value = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cap_value[i*XLEN +: XLEN] = resolve(in_src_en[i], in_src_addr[i*ADDR_W +: ADDR_W],
                                                rf_read_value[i*XLEN +: XLEN],
                                                byp_valid, byp_addr, byp_value);
            snoop_value[i*XLEN +: XLEN] = resolve(src_en_q[i], src_addr_q[i*ADDR_W +: ADDR_W],
                                                  out_src_value[i*XLEN +: XLEN],
                                                  byp_valid, byp_addr, byp_value);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid     <= 1'b0;
            out_payload   <= '0;
            out_src_value <= '0;
            src_addr_q    <= '0;
            src_en_q      <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_payload   <= in_payload;
            out_src_value <= cap_value;
            src_addr_q    <= in_src_addr;
            src_en_q      <= in_src_en;
        end else if (out_valid && !out_ready) begin
            // Held op keeps tracking write-backs so it never leaves stale.
            out_src_value <= snoop_value;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_read_bypass_stage.sv
// Directed bench for reg_read_bypass_stage with default parameters:
// vector table for operand resolution plus hand-written stall/flush/reset/flow sequences.
module tb_reg_read_bypass_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_payload;
    logic [14:0]  in_src_addr;
    logic [2:0]   in_src_en;
    logic [14:0]  rf_read_addr;
    logic [95:0]  rf_read_value;
    logic [1:0]   byp_valid;
    logic [9:0]   byp_addr;
    logic [63:0]  byp_value;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_payload;
    logic [95:0]  out_src_value;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_read_bypass_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_src_addr(in_src_addr), .in_src_en(in_src_en),
        .rf_read_addr(rf_read_addr), .rf_read_value(rf_read_value),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_value(byp_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_src_value(out_src_value)
    );

    typedef struct {
        logic [127:0] pay;
        logic [14:0]  addr;
        logic [2:0]   en;
        logic [95:0]  rf;
        logic [1:0]   bv;
        logic [9:0]   ba;
        logic [63:0]  bd;
        logic [95:0]  exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [127:0] pay, input logic [14:0] addr, input logic [2:0] en,
                         input logic [95:0] rf, input logic [1:0] bv, input logic [9:0] ba,
                         input logic [63:0] bd);
        in_payload    = pay;
        in_src_addr   = addr;
        in_src_en     = en;
        rf_read_value = rf;
        byp_valid     = bv;
        byp_addr      = ba;
        byp_value     = bd;
    endtask

    initial begin
        int sent, recv, exp_out;
        logic acc, cons;

        vecs[0] = '{128'hA0, {5'd3, 5'd2, 5'd1}, 3'b111, {32'h33, 32'h22, 32'h11},
                    2'b00, 10'd0, 64'd0, {32'h33, 32'h22, 32'h11}};
        vecs[1] = '{128'hA1, {5'd9, 5'd8, 5'd7}, 3'b111, {32'h3, 32'h2, 32'h1},
                    2'b11, {5'd7, 5'd7}, {32'hB, 32'hA}, {32'h3, 32'h2, 32'hA}};
        vecs[2] = '{128'hA2, {5'd6, 5'd4, 5'd0}, 3'b111, {32'h66, 32'h44, 32'h55},
                    2'b11, {5'd4, 5'd0}, {32'h99, 32'h77}, {32'h66, 32'h99, 32'h0}};
        vecs[3] = '{128'hA3, {5'd3, 5'd2, 5'd1}, 3'b011, {32'hFFFF, 32'h22, 32'h11},
                    2'b00, 10'd0, 64'd0, {32'h0, 32'h22, 32'h11}};
        vecs[4] = '{128'hA4, {5'd3, 5'd2, 5'd1}, 3'b111, {32'h33, 32'h22, 32'h11},
                    2'b10, {5'd2, 5'd1}, {32'hBEEF, 32'hDEAD}, {32'h33, 32'hBEEF, 32'h11}};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(128'h0, 15'd0, 3'b000, 96'd0, 2'b00, 10'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset out_payload", out_payload, 128'd0);
        chk("reset out_src_value", {32'd0, out_src_value}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready", {127'd0, in_ready}, 128'd1);

        // Back-to-back table vectors with out_ready held high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive(vecs[i].pay, vecs[i].addr, vecs[i].en, vecs[i].rf, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            #1;
            chk($sformatf("vec%0d rf_read_addr", i), {113'd0, rf_read_addr}, {113'd0, vecs[i].addr});
            chk($sformatf("vec%0d in_ready", i), {127'd0, in_ready}, 128'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), {127'd0, out_valid}, 128'd1);
            chk($sformatf("vec%0d out_payload", i), out_payload, vecs[i].pay);
            chk($sformatf("vec%0d out_src_value", i), {32'd0, out_src_value}, {32'd0, vecs[i].exp});
        end
        @(negedge clk);
        in_valid = 1'b0;
        drive(128'h0, 15'd0, 3'b000, 96'd0, 2'b00, 10'd0, 64'd0);
        @(posedge clk);
        #1;
        chk("drain out_valid", {127'd0, out_valid}, 128'd0);

        // Stall snoop: slot0 x0, slot1 x5 = 0x100, slot2 x5 but disabled.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        drive(128'hC0FFEE, {5'd5, 5'd5, 5'd0}, 3'b011, {32'h7, 32'h100, 32'h9}, 2'b00, 10'd0, 64'd0);
        @(posedge clk);
        #1;
        chk("stall capture", {32'd0, out_src_value}, {32'd0, 32'h0, 32'h100, 32'h0});
        @(negedge clk);
        drive(128'hBAD, {5'd1, 5'd1, 5'd1}, 3'b111, {32'h1, 32'h1, 32'h1}, 2'b00, 10'd0, 64'd0);
        #1;
        chk("stall1 in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        @(negedge clk);
        byp_valid = 2'b11; byp_addr = {5'd0, 5'd5}; byp_value = {32'h300, 32'h200};
        #1;
        chk("stall2 in_ready", {127'd0, in_ready}, 128'd0);
        chk("stall2 value before edge", {32'd0, out_src_value}, {32'd0, 32'h0, 32'h100, 32'h0});
        @(posedge clk);
        @(negedge clk);
        byp_valid = 2'b00;
        #1;
        chk("stall3 in_ready", {127'd0, in_ready}, 128'd0);
        chk("stall3 snooped value", {32'd0, out_src_value}, {32'd0, 32'h0, 32'h200, 32'h0});
        chk("stall3 payload", out_payload, 128'hC0FFEE);
        chk("stall3 out_valid", {127'd0, out_valid}, 128'd1);

        // Consume and accept in the same cycle.
        out_ready = 1'b1;
        drive(128'hD00D, {5'd3, 5'd2, 5'd1}, 3'b111, {32'h33, 32'h22, 32'h11}, 2'b00, 10'd0, 64'd0);
        #1;
        chk("swap in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        chk("swap payload", out_payload, 128'hD00D);
        chk("swap out_valid", {127'd0, out_valid}, 128'd1);

        // Flush while stalled with a new op offered.
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b1;
        drive(128'hF1F1, {5'd3, 5'd2, 5'd1}, 3'b111, {32'h3, 32'h2, 32'h1}, 2'b00, 10'd0, 64'd0);
        #1;
        chk("flush in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #1;
        chk("flush out_valid", {127'd0, out_valid}, 128'd0);
        chk("flush out_payload", out_payload, 128'd0);
        chk("flush out_src_value", {32'd0, out_src_value}, 128'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-flush out_valid", {127'd0, out_valid}, 128'd0);

        // Reset while stalled with an op offered.
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(128'hE2E2, {5'd3, 5'd2, 5'd1}, 3'b111, {32'h3, 32'h2, 32'h1}, 2'b00, 10'd0, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst out_payload", out_payload, 128'd0);
        chk("rst out_src_value", {32'd0, out_src_value}, 128'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Flow: 8 ops with out_ready toggling; order, no loss, no duplication.
        sent = 0; recv = 0; exp_out = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            in_valid   = (sent < 8);
            in_payload = 128'h500 + 128'(sent);
            out_ready  = cyc[0];
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                chk($sformatf("flow op%0d payload", exp_out), out_payload, 128'h500 + 128'(exp_out));
                exp_out++;
                recv++;
            end
            @(posedge clk);
            if (acc) sent++;
            if (recv == 8) break;
        end
        chk("flow ops received", 128'(recv), 128'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flow idle out_valid", {127'd0, out_valid}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
